// File: rtl/ex_mem_dump_pkg.sv
// Shared constants and helpers for the pipeline-register debug dump blocks.
// Holds the dump FSM encoding, field numbering and the byte-select helper.
package ex_mem_dump_pkg;

  // Dump controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

  // Field numbering inside a snapshot (stream order)
  localparam int FLD_CTRL    = 0;
  localparam int FLD_PC_ADDR = 1;
  localparam int FLD_PC_NEXT = 2;
  localparam int FLD_ALU     = 3;
  localparam int FLD_DATA2   = 4;
  localparam int FLD_INSTR   = 5;

  localparam int N_FIELDS       = 6;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hE3;

  // Snapshot of all captured fields, field 0 in the low word
  typedef logic [N_FIELDS-1:0][WORD_W-1:0] snap_t;

  // Select payload byte p: word p>>2, little-endian byte p[1:0]
  function automatic logic [7:0] payload_byte(input snap_t snap, input logic [4:0] p);
    logic [WORD_W-1:0] w;
    logic [7:0]        b;
    w = {WORD_W{1'b0}};
    b = 8'h00;
    if (p[4:2] < 3'(N_FIELDS)) begin
      w = snap[p[4:2]];
    end else begin
      w = {WORD_W{1'b0}};
    end
    case (p[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ex_mem_dump.sv
// EX/MEM latch dump: snapshots the six EX/MEM fields on request and
// streams them byte by byte (optional header first) over valid/ready.
// All outputs are registered from the next-state values.
module ex_mem_dump
  import ex_mem_dump_pkg::*;
#(
  parameter int         DATA_WIDTH  = 32,
  parameter int         SEND_HEADER = 1,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_pc_addr,
  input  logic [DATA_WIDTH-1:0] i_pc_next,
  input  logic [DATA_WIDTH-1:0] i_alu,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic                  i_start,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  // Index of the final byte of the stream
  localparam logic [4:0] LAST = 5'(N_FIELDS * BYTES_PER_WORD - 1 + SEND_HEADER);

  dump_state_e state_r, state_next_s;
  logic [4:0]  idx_r, idx_next_s;
  snap_t       snap_r, snap_next_s;

  logic [7:0]  tx_data_r, tx_data_next_s;
  logic        tx_valid_r, tx_valid_next_s;
  logic        busy_r, busy_next_s;
  logic        done_r, done_next_s;

  // Byte at stream index idx: header slot first when enabled
  function automatic logic [7:0] stream_byte(input logic [4:0] idx, input snap_t snap);
    logic [7:0] b;
    if ((SEND_HEADER != 0) && (idx == 5'd0)) begin
      b = HEADER_BYTE;
    end else begin
      b = payload_byte(snap, idx - 5'(SEND_HEADER));
    end
    return b;
  endfunction

  // Next-state, snapshot capture and next output values
  always_comb begin
    state_next_s    = state_r;
    idx_next_s      = idx_r;
    snap_next_s     = snap_r;
    tx_valid_next_s = 1'b0;
    tx_data_next_s  = 8'h00;
    busy_next_s     = 1'b0;
    done_next_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          snap_next_s[FLD_CTRL]    = i_ctrl;
          snap_next_s[FLD_PC_ADDR] = i_pc_addr;
          snap_next_s[FLD_PC_NEXT] = i_pc_next;
          snap_next_s[FLD_ALU]     = i_alu;
          snap_next_s[FLD_DATA2]   = i_data2;
          snap_next_s[FLD_INSTR]   = i_instr;
          idx_next_s               = 5'd0;
          state_next_s             = ST_SEND;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (tx_valid_r && i_tx_ready) begin
          if (idx_r == LAST) begin
            state_next_s = ST_DONE;
          end else begin
            idx_next_s = idx_r + 5'd1;
          end
        end else begin
          idx_next_s = idx_r;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    if (state_next_s == ST_SEND) begin
      tx_valid_next_s = 1'b1;
      tx_data_next_s  = stream_byte(idx_next_s, snap_next_s);
    end else begin
      tx_valid_next_s = 1'b0;
      tx_data_next_s  = 8'h00;
    end
    busy_next_s = (state_next_s != ST_IDLE);
    done_next_s = (state_next_s == ST_DONE);
  end

  // State, index, snapshot and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= 5'd0;
      snap_r     <= '0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      idx_r      <= idx_next_s;
      snap_r     <= snap_next_s;
      tx_data_r  <= tx_data_next_s;
      tx_valid_r <= tx_valid_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
    end
  end

  assign o_tx_data  = tx_data_r;
  assign o_tx_valid = tx_valid_r;
  assign o_busy     = busy_r;
  assign o_done     = done_r;

endmodule
